// File: rtl/rr_reg_arbiter.sv
// rr_reg_arbiter: shares one W-bit register between N requesters.
// A request in IDLE wins a one-cycle LOAD (grant pulse), the winner's data
// is captured at the end of LOAD, then HOLD_CYCLES idle cycles pass before
// the next arbitration.
// Arbitration is round-robin from (last_id+1) by default.
// Defining RR_REG_ARBITER_FIXED_PRIO_EN selects fixed lowest-index priority.
// All outputs come straight from flops.
module rr_reg_arbiter #(
    parameter int N           = 4,
    parameter int W           = 8,
    parameter int HOLD_CYCLES = 2,
    localparam int LW         = (N > 1) ? $clog2(N) : 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [N-1:0]   req,
    input  logic [N*W-1:0] wdata,
    output logic [N-1:0]   grant,
    output logic           busy,
    output logic [W-1:0]   q,
    output logic           q_valid,
    output logic [LW-1:0]  last_id
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    logic [1:0]    state_reg;
    logic [N-1:0]  grant_reg;
    logic          busy_reg;
    logic [W-1:0]  q_reg;
    logic          q_valid_reg;
    logic [LW-1:0] last_id_reg;
    logic [LW-1:0] winner_reg;
    logic [3:0]    hold_cnt_reg;

    logic          win_found;
    logic [LW-1:0] win_idx;
    logic [N-1:0]  grant_next;
    int            rr_idx;

    // Unpacked view of the packed write data, one slice per requester
    logic [W-1:0]  slice [N];

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_slice
            assign slice[gi] = wdata[gi*W +: W];
        end
    endgenerate

    // Pick the winner among the current requests
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        rr_idx    = 0;
`ifdef RR_REG_ARBITER_FIXED_PRIO_EN
        // Lowest set bit always wins; last_id is only reported
        for (int i = 0; i < N; i++) begin
            if (!win_found && req[i[LW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = i[LW-1:0];
            end
        end
`else
        // Scan upward from the slot after the previous winner, wrapping at N.
        // The sum stays below 2N, so one conditional subtract is a full mod N.
        for (int off = 1; off <= N; off++) begin
            rr_idx = int'(last_id_reg) + off;
            if (rr_idx >= N) begin
                rr_idx = rr_idx - N;
            end
            if (!win_found && req[rr_idx[LW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = rr_idx[LW-1:0];
            end
        end
`endif
        grant_next = N'(1) << win_idx;
    end

    // Control FSM, shared register and status flops
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= S_IDLE;
            grant_reg    <= '0;
            busy_reg     <= 1'b0;
            q_reg        <= '0;
            q_valid_reg  <= 1'b0;
            last_id_reg  <= LW'(N - 1);
            winner_reg   <= '0;
            hold_cnt_reg <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (win_found) begin
                        grant_reg  <= grant_next;
                        winner_reg <= win_idx;
                        busy_reg   <= 1'b1;
                        state_reg  <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    // Capture regardless of whether the winner still requests
                    q_reg       <= slice[winner_reg];
                    q_valid_reg <= 1'b1;
                    last_id_reg <= winner_reg;
                    grant_reg   <= '0;
                    if (HOLD_CYCLES > 0) begin
                        hold_cnt_reg <= 4'(HOLD_CYCLES - 1);
                        state_reg    <= S_HOLD;
                    end else begin
                        busy_reg  <= 1'b0;
                        state_reg <= S_IDLE;
                    end
                end
                S_HOLD: begin
                    // Requests are deliberately ignored until back in IDLE
                    if (hold_cnt_reg == 4'd0) begin
                        busy_reg  <= 1'b0;
                        state_reg <= S_IDLE;
                    end else begin
                        hold_cnt_reg <= hold_cnt_reg - 4'd1;
                    end
                end
                default: begin
                    grant_reg <= '0;
                    busy_reg  <= 1'b0;
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    assign grant   = grant_reg;
    assign busy    = busy_reg;
    assign q       = q_reg;
    assign q_valid = q_valid_reg;
    assign last_id = last_id_reg;

endmodule

// File: tb/tb_rr_reg_arbiter.sv
// Testbench for rr_reg_arbiter (N=4, W=8, HOLD_CYCLES=2).
// Expected grants are queued when stimulus is applied; a monitor pops one
// entry per observed grant and checks the captured data one cycle later.
module tb_rr_reg_arbiter;

    localparam int N    = 4;
    localparam int W    = 8;
    localparam int HOLD = 2;
    localparam int LW   = 2;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [N-1:0]   req = '0;
    logic [N*W-1:0] wdata = '0;
    logic [N-1:0]   grant;
    logic           busy;
    logic [W-1:0]   q;
    logic           q_valid;
    logic [LW-1:0]  last_id;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        logic [N-1:0]  grant;
        logic [W-1:0]  data;
        logic [LW-1:0] id;
        int            gap;   // required grant-to-grant spacing, 0 = unchecked
        bit            rst;   // reset hits the LOAD cycle: expect no capture
    } exp_t;

    exp_t sb[$];

    rr_reg_arbiter #(.N(N), .W(W), .HOLD_CYCLES(HOLD)) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .wdata   (wdata),
        .grant   (grant),
        .busy    (busy),
        .q       (q),
        .q_valid (q_valid),
        .last_id (last_id)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic exp_t mk(input logic [N-1:0] g, input logic [W-1:0] d,
                                input logic [LW-1:0] id, input int gap, input bit rst);
        exp_t e;
        e.grant = g; e.data = d; e.id = id; e.gap = gap; e.rst = rst;
        return e;
    endfunction

    // Scoreboard monitor: sampled on the falling edge
    bit   pend = 1'b0;
    exp_t cur;
    int   last_gcyc = 0;

    always @(negedge clk) begin
        if (pend) begin
            pend = 1'b0;
            if (cur.rst) begin
                check_value("rst_grant",   grant,   0);
                check_value("rst_q",       q,       0);
                check_value("rst_q_valid", q_valid, 0);
                check_value("rst_last_id", last_id, N - 1);
                check_value("rst_busy",    busy,    0);
            end else begin
                check_value("grant_width", grant,   0);
                check_value("q_data",      q,       cur.data);
                check_value("q_valid",     q_valid, 1);
                check_value("last_id",     last_id, cur.id);
            end
            $display("txn grant=%b q=%02h q_valid=%0b last_id=%0d reset_hit=%0b",
                     cur.grant, q, q_valid, last_id, cur.rst);
        end
        if (grant != '0) begin
            if (sb.size() == 0) begin
                check_value("unexpected_grant", grant, 0);
            end else begin
                cur = sb.pop_front();
                check_value("grant", grant, cur.grant);
                check_value("busy_in_load", busy, 1);
                if (cur.gap > 0) check_value("grant_gap", cyc - last_gcyc, cur.gap);
                pend = 1'b1;
            end
            last_gcyc = cyc;
        end
    end

    // Wait for n grants (bounded); requests are dropped on the last one
    task automatic wait_grants(input int n, input int budget);
        int seen = 0;
        for (int c = 0; c < budget && seen < n; c++) begin
            @(negedge clk);
            if (grant != '0) begin
                seen++;
                if (seen == n) req = '0;
            end
        end
        check_value("grant_count", seen, n);
        req = '0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        int busy_cnt;
        int seen;

        // Reset, then idle with no requests
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_value("idle_q",       q,       0);
            check_value("idle_q_valid", q_valid, 0);
            check_value("idle_grant",   grant,   0);
            check_value("idle_busy",    busy,    0);
            check_value("idle_last_id", last_id, 3);
        end

        // Single request from requester 2
        @(posedge clk); #1;
        wdata[2*W +: W] = 8'hA5;
        sb.push_back(mk(4'b0100, 8'hA5, 2, 0, 1'b0));
        req = 4'b0100;
        busy_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (grant != '0) req = '0;
        end
        check_value("busy_cycles", busy_cnt, 1 + HOLD);

        // Round-robin fairness under continuous all-ones requests
        do_reset();
        wdata = {8'h40, 8'h30, 8'h20, 8'h10};
`ifdef RR_REG_ARBITER_FIXED_PRIO_EN
        sb.push_back(mk(4'b0001, 8'h10, 0, 0, 1'b0));
        for (int i = 0; i < 4; i++) sb.push_back(mk(4'b0001, 8'h10, 0, 2 + HOLD, 1'b0));
`else
        sb.push_back(mk(4'b0001, 8'h10, 0, 0,        1'b0));
        sb.push_back(mk(4'b0010, 8'h20, 1, 2 + HOLD, 1'b0));
        sb.push_back(mk(4'b0100, 8'h30, 2, 2 + HOLD, 1'b0));
        sb.push_back(mk(4'b1000, 8'h40, 3, 2 + HOLD, 1'b0));
        sb.push_back(mk(4'b0001, 8'h10, 0, 2 + HOLD, 1'b0));
`endif
        req = 4'b1111;
        wait_grants(5, 40);
        repeat (6) @(posedge clk);

        // Wrap and skip: from last_id=3, req=1010 gives 1 then 3
        do_reset();
        wdata = {8'h44, 8'h33, 8'h22, 8'h11};
`ifdef RR_REG_ARBITER_FIXED_PRIO_EN
        sb.push_back(mk(4'b0010, 8'h22, 1, 0,        1'b0));
        sb.push_back(mk(4'b0010, 8'h22, 1, 2 + HOLD, 1'b0));
`else
        sb.push_back(mk(4'b0010, 8'h22, 1, 0,        1'b0));
        sb.push_back(mk(4'b1000, 8'h44, 3, 2 + HOLD, 1'b0));
`endif
        req = 4'b1010;
        wait_grants(2, 20);
        repeat (6) @(posedge clk);

        // Reset asserted during the LOAD cycle: nothing is captured
        #1;
        wdata[0 +: W] = 8'hFF;
        sb.push_back(mk(4'b0001, 8'hFF, 0, 0, 1'b1));
        req = 4'b0001;
        seen = 0;
        for (int c = 0; c < 10 && seen == 0; c++) begin
            @(negedge clk);
            if (grant != '0) begin
                seen = 1;
                reset = 1'b1;
                req = '0;
            end
        end
        check_value("midrst_grant_seen", seen, 1);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_value("post_rst_busy",    busy,    0);
            check_value("post_rst_q_valid", q_valid, 0);
        end

        check_value("scoreboard_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
